simple_pipe_fetch: RTL

- Instruction-fetch front end that feeds the 4-register add/set/nand pipeline core.
- Holds a small writable instruction memory (IMEM) and a program counter.
- On a start command, streams a contiguous run of 8-bit instructions into a first-word-fall-through FIFO.
- The FIFO drives the core's inst/inst_valid/inst_ready handshake, so core back-pressure (stallex/stallwb) propagates cleanly into fetch.

---
 rtl/simple_pipe_pkg.sv | 17 +
 rtl/simple_pipe_fifo.sv | 54 +++++
 rtl/simple_pipe_fetch.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/simple_pipe_pkg.sv
// Shared definitions for the simple add/set/nand pipeline and its fetch front end.
package simple_pipe_pkg;

   localparam int unsigned INST_W = 8;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b01;
   localparam logic [1:0] OP_SET  = 2'b10;
   localparam logic [1:0] OP_NAND = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/simple_pipe_fifo.sv
// First-word-fall-through synchronous FIFO; head is valid whenever empty is low.
module simple_pipe_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 8,
   localparam int unsigned PW = $clog2(DEPTH),
   localparam int unsigned CW = PW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [CW-1:0]    count,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage array, intentionally not reset.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];
   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/simple_pipe_fetch.sv
// Instruction-fetch front end: IMEM + PC + credit-based streaming into an FWFT FIFO.
module simple_pipe_fetch
   import simple_pipe_pkg::*;
#(
   parameter int unsigned IMEM_DEPTH = 16,
   parameter int unsigned AW         = 4,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              imem_wen,
   input  logic [AW-1:0]     imem_waddr,
   input  logic [INST_W-1:0] imem_wdata,
   input  logic              start,
   input  logic [AW-1:0]     start_pc,
   input  logic [AW:0]       inst_count,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic [AW-1:0]     pc,
   output logic [INST_W-1:0] inst,
   output logic              inst_valid,
   input  logic              inst_ready
);

   localparam int unsigned FCW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned OCW = FCW + 1;

   fetch_state_t      state_q, state_d;
   logic [AW-1:0]     pc_q, pc_d;
   logic [AW:0]       remaining_q, remaining_d;
   logic              rd_pending_q, rd_pending_d;
   logic              done_q, done_d;
   logic [INST_W-1:0] rd_data_q;
   logic [INST_W-1:0] imem_q [IMEM_DEPTH];

   logic              issue_c;
   logic              push_c;
   logic              pop_c;
   logic              credit_ok_c;
   logic [OCW-1:0]    occupancy_c;
   logic [FCW-1:0]    fifo_count;
   logic              fifo_empty;
   logic              fifo_full;

   assign pop_c  = inst_valid && inst_ready;
   assign push_c = rd_pending_q && !abort;

   // Credit check counts the in-flight read and credits a same-cycle pop for 1/cycle throughput.
   assign occupancy_c = OCW'(fifo_count) + OCW'(rd_pending_q);
   assign credit_ok_c = occupancy_c < (OCW'(FIFO_DEPTH) + OCW'(pop_c));

   // Next-state, PC and read-issue logic; abort overrides everything, including start.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      remaining_d = remaining_q;
      done_d      = 1'b0;
      issue_c     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (inst_count != '0) begin
                  state_d     = FETCH;
                  pc_d        = start_pc;
                  remaining_d = inst_count;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         FETCH: begin
            if ((remaining_q != '0) && credit_ok_c) begin
               issue_c     = 1'b1;
               pc_d        = pc_q + AW'(1);
               remaining_d = remaining_q - (AW+1)'(1);
               if (remaining_q == (AW+1)'(1)) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!rd_pending_q && fifo_empty && !push_c) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (abort) begin
         state_d     = IDLE;
         pc_d        = pc_q;
         remaining_d = '0;
         done_d      = 1'b0;
         issue_c     = 1'b0;
      end

      rd_pending_d = issue_c;
   end

   // Control state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         pc_q         <= '0;
         remaining_q  <= '0;
         rd_pending_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         remaining_q  <= remaining_d;
         rd_pending_q <= rd_pending_d;
         done_q       <= done_d;
      end
   end

   // IMEM with synchronous write and registered read; same-address read sees old data.
   always_ff @(posedge clk) begin
      if (imem_wen) imem_q[imem_waddr] <= imem_wdata;
      if (issue_c)  rd_data_q <= imem_q[pc_q];
   end

   simple_pipe_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (INST_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_c),
      .pop   (pop_c),
      .flush (abort),
      .wdata (rd_data_q),
      .count (fifo_count),
      .head  (inst),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   // The credit scheme must never let a read land in a full FIFO without a pop.
   push_no_overflow_a: assert property (@(posedge clk) disable iff (rst)
      !(push_c && fifo_full && !pop_c));

   assign inst_valid = !fifo_empty;
   assign busy       = (state_q != IDLE);
   assign done       = done_q;
   assign pc         = pc_q;

endmodule
